lcd_bus_writer: RTL and testbench



---
 rtl/lcd_pkg.sv | 51 +++++
 rtl/lcd_delay_counter.sv | 29 ++
 rtl/lcd_bus_writer.sv | 162 ++++++++++++++++
 tb/tb_lcd_bus_writer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 bus writer: state encoding, init ROM, commands.
package lcd_pkg;

  localparam int unsigned CNT_W    = 20;
  localparam int unsigned INIT_LEN = 6;
  localparam int unsigned IDX_W    = 3;

  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_HOME         = 8'h02;
  localparam logic [7:0] CMD_FSET_8BIT_2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON      = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_INC    = 8'h06;

  typedef enum logic [2:0] {
    ST_PWRUP     = 3'd0,
    ST_INIT_LOAD = 3'd1,
    ST_IDLE      = 3'd2,
    ST_SETUP     = 3'd3,
    ST_EPULSE    = 3'd4,
    ST_HOLD      = 3'd5,
    ST_EXEC      = 3'd6
  } lcd_state_t;

  // One byte as presented on the LCD bus.
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_byte_t;

  // Power-on init sequence: 8-bit/2-line x3, display on, clear, entry increment.
  function automatic logic [7:0] init_rom(input logic [IDX_W-1:0] idx);
    logic [7:0] val;
    val = 8'h00;
    case (idx)
      3'd0:    val = CMD_FSET_8BIT_2L;
      3'd1:    val = CMD_FSET_8BIT_2L;
      3'd2:    val = CMD_FSET_8BIT_2L;
      3'd3:    val = CMD_DISP_ON;
      3'd4:    val = CMD_CLEAR;
      3'd5:    val = CMD_ENTRY_INC;
      default: val = 8'h00;
    endcase
    return val;
  endfunction

  // Clear (0x01) and home (0x02/0x03) need the long execution wait; 0x00 does not.
  function automatic logic is_long_cmd(input lcd_byte_t b);
    return (!b.rs) && (b.data[7:2] == 6'd0) && (b.data != 8'h00);
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable 20-bit down-counter; done flag is high while the count is zero.
module lcd_delay_counter
  import lcd_pkg::*;
#(
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done_c
);

  logic [CNT_W-1:0] r_cnt;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= CNT_W'(RST_VAL);
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/lcd_bus_writer.sv
// HD44780 8-bit write engine: power-on init, then one byte per valid/ready handshake.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int unsigned PWRUP_CYC     = 750000,
  parameter int unsigned SETUP_CYC     = 4,
  parameter int unsigned E_PULSE_CYC   = 16,
  parameter int unsigned HOLD_CYC      = 4,
  parameter int unsigned EXEC_CYC      = 2500,
  parameter int unsigned LONG_EXEC_CYC = 82000
) (
  input  logic       iCLK_50MHZ,
  input  logic       iRST_N,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iVALID,
  output logic       oREADY,
  output logic       oINIT_DONE,
  inout  wire  [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic       LCD_RS
);

  // Phase lengths as counter load values (N-1 so each phase lasts N cycles).
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EPULSE_LD = CNT_W'(E_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LD   = CNT_W'(EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LEXEC_LD  = CNT_W'(LONG_EXEC_CYC - 1);

  lcd_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  lcd_byte_t        r_byte, w_byte_nxt;
  logic             r_e, w_e_nxt;
  logic             r_ready, w_ready_nxt;
  logic             r_init_done, w_init_done_nxt;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_done;

  lcd_delay_counter #(
    .RST_VAL (PWRUP_CYC - 1)
  ) u_delay (
    .clk        (iCLK_50MHZ),
    .rst_n      (iRST_N),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done_c   (w_done)
  );

  // State and output registers; reset drops E asynchronously and restarts init.
  always_ff @(posedge iCLK_50MHZ or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state     <= ST_PWRUP;
      r_idx       <= '0;
      r_byte      <= '0;
      r_e         <= 1'b0;
      r_ready     <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_byte      <= w_byte_nxt;
      r_e         <= w_e_nxt;
      r_ready     <= w_ready_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  // Next-state, next-output and delay-counter load decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_byte_nxt      = r_byte;
    w_e_nxt         = 1'b0;
    w_ready_nxt     = 1'b0;
    w_init_done_nxt = r_init_done;
    w_load          = 1'b0;
    w_load_val      = '0;

    case (r_state)
      ST_PWRUP: begin
        if (w_done) begin
          w_state_nxt = ST_INIT_LOAD;
        end
      end

      ST_INIT_LOAD: begin
        w_byte_nxt.rs   = 1'b0;
        w_byte_nxt.data = init_rom(r_idx);
        w_state_nxt     = ST_SETUP;
        w_load          = 1'b1;
        w_load_val      = SETUP_LD;
      end

      ST_IDLE: begin
        w_ready_nxt = 1'b1;
        if (iVALID && r_ready) begin
          w_byte_nxt.rs   = iRS;
          w_byte_nxt.data = iDATA;
          w_ready_nxt     = 1'b0;
          w_state_nxt     = ST_SETUP;
          w_load          = 1'b1;
          w_load_val      = SETUP_LD;
        end
      end

      ST_SETUP: begin
        if (w_done) begin
          w_e_nxt     = 1'b1;
          w_state_nxt = ST_EPULSE;
          w_load      = 1'b1;
          w_load_val  = EPULSE_LD;
        end
      end

      ST_EPULSE: begin
        w_e_nxt = 1'b1;
        if (w_done) begin
          w_e_nxt     = 1'b0;
          w_state_nxt = ST_HOLD;
          w_load      = 1'b1;
          w_load_val  = HOLD_LD;
        end
      end

      ST_HOLD: begin
        if (w_done) begin
          w_state_nxt = ST_EXEC;
          w_load      = 1'b1;
          w_load_val  = is_long_cmd(r_byte) ? LEXEC_LD : EXEC_LD;
        end
      end

      ST_EXEC: begin
        if (w_done) begin
          if (!r_init_done && (r_idx < IDX_W'(INIT_LEN - 1))) begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = ST_INIT_LOAD;
          end else begin
            w_init_done_nxt = 1'b1;
            w_ready_nxt     = 1'b1;
            w_state_nxt     = ST_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = ST_PWRUP;
      end
    endcase
  end

  assign oREADY     = r_ready;
  assign oINIT_DONE = r_init_done;
  assign LCD_DATA   = r_byte.data;
  assign LCD_RS     = r_byte.rs;
  assign LCD_E      = r_e;
  assign LCD_RW     = 1'b0;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Directed self-checking bench for lcd_bus_writer with shortened timing.
module tb_lcd_bus_writer;

  localparam int unsigned PWRUP_CYC     = 20;
  localparam int unsigned SETUP_CYC     = 2;
  localparam int unsigned E_PULSE_CYC   = 3;
  localparam int unsigned HOLD_CYC      = 2;
  localparam int unsigned EXEC_CYC      = 10;
  localparam int unsigned LONG_EXEC_CYC = 40;

  logic       clk;
  logic       rst_n;
  logic [7:0] idata;
  logic       irs;
  logic       ivalid;
  logic       oready;
  logic       oinit_done;
  wire  [7:0] lcd_data;
  logic       lcd_rw;
  logic       lcd_e;
  logic       lcd_rs;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0] e_data_q[$];
  int         e_rise_q[$];
  int         e_fall_cyc = 0;
  int         rdy_rises  = 0;
  int         done_rises = 0;
  logic       e_prev = 1'b0, rdy_prev = 1'b0, done_prev = 1'b0;

  lcd_bus_writer #(
    .PWRUP_CYC     (PWRUP_CYC),
    .SETUP_CYC     (SETUP_CYC),
    .E_PULSE_CYC   (E_PULSE_CYC),
    .HOLD_CYC      (HOLD_CYC),
    .EXEC_CYC      (EXEC_CYC),
    .LONG_EXEC_CYC (LONG_EXEC_CYC)
  ) dut (
    .iCLK_50MHZ (clk),
    .iRST_N     (rst_n),
    .iDATA      (idata),
    .iRS        (irs),
    .iVALID     (ivalid),
    .oREADY     (oready),
    .oINIT_DONE (oinit_done),
    .LCD_DATA   (lcd_data),
    .LCD_RW     (lcd_rw),
    .LCD_E      (lcd_e),
    .LCD_RS     (lcd_rs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle stamp: number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: log every E pulse with its data and edge stamps.
  always @(negedge clk) begin
    if (lcd_e && !e_prev) begin
      e_data_q.push_back(lcd_data);
      e_rise_q.push_back(cyc);
    end
    if (!lcd_e && e_prev) e_fall_cyc = cyc;
    if (oready && !rdy_prev) rdy_rises++;
    if (oinit_done && !done_prev) done_rises++;
    e_prev    = lcd_e;
    rdy_prev  = oready;
    done_prev = oinit_done;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!oready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(oready), 32'd1);
  endtask

  // Release reset and verify the full init sequence and its timing.
  task automatic check_init();
    logic [7:0] rom[6];
    int base, rb, db, n;
    rom[0] = 8'h38; rom[1] = 8'h38; rom[2] = 8'h38;
    rom[3] = 8'h0C; rom[4] = 8'h01; rom[5] = 8'h06;
    @(negedge clk);
    base = e_data_q.size();
    rb   = rdy_rises;
    db   = done_rises;
    rst_n = 1'b1;
    n = 0;
    while (!oinit_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("init_done_seen", 32'(oinit_done), 32'd1);
    chk("init_ready", 32'(oready), 32'd1);
    chk("init_pulses", 32'(e_data_q.size() - base), 32'd6);
    if (e_data_q.size() >= base + 6) begin
      for (int i = 0; i < 6; i++) chk($sformatf("init_byte%0d", i), 32'(e_data_q[base+i]), 32'(rom[i]));
      chk("init_gap_short", 32'(e_rise_q[base+1] - e_rise_q[base]), 32'd18);
      chk("init_gap_clear", 32'(e_rise_q[base+5] - e_rise_q[base+4]), 32'd48);
      chk("init_ready_lat", 32'(cyc - e_rise_q[base+5]), 32'd15);
    end
    repeat (10) @(negedge clk);
    chk("init_ready_rises", 32'(rdy_rises - rb), 32'd1);
    chk("init_done_rises", 32'(done_rises - db), 32'd1);
  endtask

  // Single write with exact E and ready timing; optionally poke iVALID during EXEC.
  task automatic do_write(input logic rs, input logic [7:0] d, input int exp_lat, input bit poke);
    int a, base, n;
    wait_ready("wr_ready_pre");
    base   = e_data_q.size();
    irs    = rs;
    idata  = d;
    ivalid = 1'b1;
    @(negedge clk);
    ivalid = 1'b0;
    a = cyc;
    chk("acc_ready_low", 32'(oready), 32'd0);
    chk("acc_rs", 32'(lcd_rs), 32'(rs));
    chk("acc_data", 32'(lcd_data), 32'(d));
    n = 0;
    while (!oready && n < 200) begin
      @(negedge clk);
      n++;
      if (poke && cyc == a + 10) begin
        ivalid = 1'b1; irs = ~rs; idata = 8'h55;
      end
      if (poke && cyc == a + 12) ivalid = 1'b0;
    end
    chk("wr_ready_back", 32'(oready), 32'd1);
    chk("wr_ready_lat", 32'(cyc - a), 32'(exp_lat));
    chk("wr_pulses", 32'(e_data_q.size() - base), 32'd1);
    if (e_rise_q.size() > 0) chk("wr_e_rise", 32'(e_rise_q[$] - a), 32'd2);
    chk("wr_e_fall", 32'(e_fall_cyc - a), 32'd5);
    chk("wr_data_stable", 32'(lcd_data), 32'(d));
    chk("wr_rs_stable", 32'(lcd_rs), 32'(rs));
    if (poke) begin
      repeat (5) @(negedge clk);
      chk("poke_no_accept", 32'(oready), 32'd1);
      chk("poke_data", 32'(lcd_data), 32'(d));
      chk("poke_pulses", 32'(e_data_q.size() - base), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] bb[3];
    int acc[3];
    int base, n;
    rst_n  = 1'b0;
    ivalid = 1'b0;
    irs    = 1'b0;
    idata  = 8'h00;
    bb[0] = 8'h48; bb[1] = 8'h49; bb[2] = 8'h21;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_e", 32'(lcd_e), 32'd0);
    chk("rst_rs", 32'(lcd_rs), 32'd0);
    chk("rst_data", 32'(lcd_data), 32'd0);
    chk("rst_rw", 32'(lcd_rw), 32'd0);
    chk("rst_ready", 32'(oready), 32'd0);
    chk("rst_done", 32'(oinit_done), 32'd0);

    check_init();

    // Data write 0x41, then long and short commands
    do_write(1'b1, 8'h41, 17, 1'b0);
    do_write(1'b0, 8'h01, 47, 1'b0);
    do_write(1'b0, 8'h80, 17, 1'b0);
    do_write(1'b0, 8'h02, 47, 1'b0);
    do_write(1'b0, 8'h00, 17, 1'b0);
    do_write(1'b0, 8'h04, 17, 1'b0);

    // iVALID pulsed during EXEC is ignored
    do_write(1'b0, 8'h80, 17, 1'b1);

    // Back-to-back with iVALID held high
    wait_ready("b2b_ready_pre");
    base   = e_data_q.size();
    irs    = 1'b1;
    ivalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idata = bb[k];
      wait_ready($sformatf("b2b_ready%0d", k));
      @(negedge clk);
      acc[k] = cyc;
      if (k == 2) ivalid = 1'b0;
      chk($sformatf("b2b_acc%0d", k), 32'(oready), 32'd0);
      chk($sformatf("b2b_data%0d", k), 32'(lcd_data), 32'(bb[k]));
    end
    wait_ready("b2b_ready_end");
    chk("b2b_space01", 32'(acc[1] - acc[0]), 32'd18);
    chk("b2b_space12", 32'(acc[2] - acc[1]), 32'd18);
    chk("b2b_pulses", 32'(e_data_q.size() - base), 32'd3);
    if (e_data_q.size() == base + 3) begin
      for (int k = 0; k < 3; k++) chk($sformatf("b2b_pulse%0d", k), 32'(e_data_q[base+k]), 32'(bb[k]));
    end

    // Reset while E is high during a user write
    wait_ready("rst_mid_ready");
    irs = 1'b1; idata = 8'h41; ivalid = 1'b1;
    @(negedge clk);
    ivalid = 1'b0;
    n = 0;
    while (!lcd_e && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_e_high", 32'(lcd_e), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_e_drop", 32'(lcd_e), 32'd0);
    chk("mid_done_clr", 32'(oinit_done), 32'd0);
    chk("mid_ready_clr", 32'(oready), 32'd0);
    chk("mid_data_clr", 32'(lcd_data), 32'd0);
    repeat (2) @(negedge clk);
    check_init();
    do_write(1'b1, 8'h5A, 17, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
